// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter slice.
//   - default requester count, operand and opcode widths
//   - requester-ID width helper (clog2, minimum 1)
//   - operation-counter width
//   - response-channel controller states
package alu_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_OP_W    = 3;
    localparam int CNT_W       = 16;

    // A single requester still needs one ID bit so rsp_id is never zero-width.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_model.sv
// Purely combinational ALU shared by all requesters.
// Ports:
//   a_i, b_i : operands (DATA_W)
//   op_i     : opcode (OP_W)
//   y_o      : result (DATA_W)
// Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 a<<1, 7 a>>1.
module ALU_model
    import alu_share_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] y_o
);

    // Operation select
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_W'(0): y_o = a_i + b_i;
            OP_W'(1): y_o = a_i - b_i;
            OP_W'(2): y_o = a_i & b_i;
            OP_W'(3): y_o = a_i | b_i;
            OP_W'(4): y_o = a_i ^ b_i;
            OP_W'(5): y_o = ~a_i;
            OP_W'(6): y_o = a_i << 1;
            OP_W'(7): y_o = a_i >> 1;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping modulo NUM_REQ.
// Ports:
//   req_i     : request vector
//   ptr_i     : highest-priority index
//   en_i      : grant enable (downstream can accept)
//   gnt_o     : one-hot grant, zero when disabled or idle
//   gnt_idx_o : encoded index of the winner (valid when gnt_vld_o)
//   gnt_vld_o : a grant is being issued
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_vld_o
);

    localparam logic [ID_W:0] NUM_L = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0]      sum_s;
    logic [ID_W:0]      wrap_s;
    logic [ID_W-1:0]    cand_s;
    logic               hit_s;
    logic               found_s;
    logic [ID_W-1:0]    idx_s;
    logic [NUM_REQ-1:0] gnt_s;

    // Priority scan starting at the pointer; the first hit wins.
    always_comb begin
        sum_s   = '0;
        wrap_s  = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s   = {1'b0, ptr_i} + (ID_W+1)'(k);
            wrap_s  = (sum_s >= NUM_L) ? (sum_s - NUM_L) : sum_s;
            cand_s  = wrap_s[ID_W-1:0];
            hit_s   = !found_s && req_i[cand_s];
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
    end

    // One-hot expansion gated by the enable.
    always_comb begin
        gnt_s        = '0;
        gnt_s[idx_s] = found_s & en_i;
    end

    assign gnt_o     = gnt_s;
    assign gnt_idx_o = idx_s;
    assign gnt_vld_o = found_s & en_i;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters. A round-robin
// grant selects one request per cycle; its result is registered together
// with the requester ID on a single response channel with backpressure.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : per-requester handshake
//   req_opperand_1/2, opcode : packed per-requester payload
//   rsp_valid / rsp_ready    : response handshake
//   rsp_data, rsp_id         : registered result and originating requester
//   op_count                 : wrapping count of accepted requests
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_opperand_1,
    input  logic [NUM_REQ*DATA_W-1:0] req_opperand_2,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          op_count
);

    rsp_state_e         state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               can_accept_s;
    logic               en_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               xfer_s;
    logic [DATA_W-1:0]  opa_s, opb_s, alu_y_s;
    logic [OP_W-1:0]    opc_s;

    // Grant enable depends only on the response slot and reset, never on payload.
    assign can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
    assign en_s         = can_accept_s && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (en_s),
        .gnt_o     (req_ready),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (xfer_s)
    );

    assign opa_s = req_opperand_1[int'(gnt_idx_s)*DATA_W +: DATA_W];
    assign opb_s = req_opperand_2[int'(gnt_idx_s)*DATA_W +: DATA_W];
    assign opc_s = req_opcode[int'(gnt_idx_s)*OP_W +: OP_W];

    ALU_model #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a_i  (opa_s),
        .b_i  (opb_s),
        .op_i (opc_s),
        .y_o  (alu_y_s)
    );

    // Next-state: a transfer loads the slot (even while draining), a drain
    // alone empties it, anything else holds.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer_s) begin
            state_d = ST_FULL;
            data_d  = alu_y_s;
            id_d    = gnt_idx_s;
            ptr_d   = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Response slot, pointer and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic [15:0] req_opperand_1 = 16'h0000;
    logic [15:0] req_opperand_2 = 16'h0000;
    logic [11:0] req_opcode = 12'h000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    alu_share_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opperand_1 (req_opperand_1),
        .req_opperand_2 (req_opperand_2),
        .req_opcode     (req_opcode),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .op_count       (op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // per-requester payload
    logic [3:0] o1 [4];
    logic [3:0] o2 [4];
    logic [2:0] oc [4];

    // reference model state
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt   = 16'h0000;
    int          m_ptr   = 0;
    logic [3:0]  m_data  = 4'h0;
    logic [1:0]  m_id    = 2'd0;
    logic [5:0]  sb [$];
    int          idcnt [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] t;
        case (op)
            3'd0: t = {1'b0, a} + {1'b0, b};
            3'd1: t = {1'b0, a} - {1'b0, b};
            3'd2: t = {1'b0, a & b};
            3'd3: t = {1'b0, a | b};
            3'd4: t = {1'b0, a ^ b};
            3'd5: t = {1'b0, ~a};
            3'd6: t = {a, 1'b0};
            default: t = {2'b00, a[3:1]};
        endcase
        return t[3:0];
    endfunction

    // One clock: drive at negedge, check ready, predict, check outputs after posedge.
    task automatic cycle(input logic [3:0] v, input logic rr, input logic r, input logic rnd);
        logic [3:0] er;
        logic       can;
        logic       pend;
        int         g;
        int         c;
        logic [5:0] e;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            req_opperand_1[i*4 +: 4] = o1[i];
            req_opperand_2[i*4 +: 4] = o2[i];
            req_opcode[i*3 +: 3]     = oc[i];
        end
        #1;
        can = !m_valid || rr;
        g = -1;
        for (int j = 0; j < 4; j++) begin
            c = (m_ptr + j) % 4;
            if (g < 0 && v[c]) g = c;
        end
        er = 4'b0000;
        if (!r && can && g >= 0) er[g] = 1'b1;
        check_eq("req_ready", {28'h0, req_ready}, {28'h0, er});
        pend = 1'b0;
        if (r) begin
            m_valid = 1'b0; m_cnt = 16'h0000; m_ptr = 0; m_data = 4'h0; m_id = 2'd0;
            sb.delete();
        end else if (er != 4'b0000) begin
            sb.push_back({g[1:0], alu_ref(o1[g], o2[g], oc[g])});
            m_ptr   = (g + 1) % 4;
            m_cnt   = m_cnt + 16'h0001;
            m_valid = 1'b1;
            pend    = 1'b1;
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
        check_eq("op_count", {16'h0, op_count}, {16'h0, m_cnt});
        if (pend) begin
            e      = sb.pop_front();
            m_id   = e[5:4];
            m_data = e[3:0];
            idcnt[m_id]++;
            if (rnd) begin
                o1[g] = 4'($urandom);
                o2[g] = 4'($urandom);
                oc[g] = 3'($urandom);
            end
        end
        check_eq("rsp_id", {30'h0, rsp_id}, {30'h0, m_id});
        check_eq("rsp_data", {28'h0, rsp_data}, {28'h0, m_data});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            o1[i] = 4'(i + 5); o2[i] = 4'(i + 2); oc[i] = 3'(i); idcnt[i] = 0;
        end

        // 1: reset held with all requests pending, then requester 0 first
        cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);

        // 2: lone requester 2, 3 + 1
        o1[2] = 4'b0011; o2[2] = 4'b0001; oc[2] = 3'b000;
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        check_eq("t2_data", {28'h0, rsp_data}, 32'h4);
        // drain with nothing pending: data/id held, valid drops
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);

        // 3: round robin over all four with ops 0..3 on 3/1
        cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            o1[i] = 4'd3; o2[i] = 4'd1; oc[i] = 3'(i);
        end
        for (int n = 0; n < 6; n++) cycle(4'b1111, 1'b1, 1'b0, 1'b0);

        // 4: stall three cycles then resume with no bubble
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);

        // 5: reset while stalled
        cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);

        // 6: 65536 back-to-back transfers from reset, random payloads
        cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idcnt[i] = 0;
        for (int n = 0; n < 65536; n++) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        check_eq("wrap", {16'h0, op_count}, 32'h0);
        for (int i = 0; i < 4; i++) check_eq("id_count", idcnt[i], 32'd16384);
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
